// File: rtl/sent_rx_frame_ctrl.sv
// SENT receive frame controller: tracks frame position from measured periods,
// checks CRC4, delivers frames and assembles the 16-frame short serial message.
module sent_rx_frame_ctrl #(
  parameter int NIBBLES  = 6,
  parameter int PAUSE_EN = 0,
  parameter int TICK_W   = 10
) (
  input  logic              clk_rx,
  input  logic              reset,
  input  logic              pulse_valid,
  input  logic [TICK_W-1:0] pulse_ticks,
  output logic              frame_valid,
  output logic [3:0]        status_out,
  output logic [23:0]       data_out,
  output logic [3:0]        crc_out,
  output logic              crc_error,
  output logic              nibble_error,
  output logic              sync_error,
  output logic              msg_valid,
  output logic [15:0]       msg_data
);

  typedef enum logic [2:0] {IDLE, STATUS, DATA, CRC, PAUSE, WAIT_SYNC} state_t;

  localparam logic [3:0] CRC_SEED = 4'b0101;

  // One nibble of CRC4 (x^4+x^3+x^2+1), MSB first.
  function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ nib[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
    end
    return c;
  endfunction

  state_t      state_reg;
  logic [3:0]  crc_acc_reg;
  logic [2:0]  nib_cnt_reg;
  logic [3:0]  status_reg;
  logic [23:0] data_shadow_reg;
  logic [3:0]  msg_cnt_reg;
  logic [15:0] msg_shift_reg;

  logic [31:0]       ticks32;
  logic [TICK_W-1:0] nib_diff;
  logic [3:0]        nib_val;
  logic              is_sync;
  logic              is_nib;
  logic              is_pause;
  logic              crc_bad;

  assign ticks32  = 32'(pulse_ticks);
  assign nib_diff = pulse_ticks - TICK_W'(12);
  assign nib_val  = nib_diff[3:0];
  assign is_sync  = (ticks32 == 32'd56);
  assign is_nib   = (ticks32 >= 32'd12) && (ticks32 <= 32'd27);
  assign is_pause = (ticks32 >= 32'd12) && (ticks32 <= 32'd768);
  assign crc_bad  = (crc_step(crc_acc_reg, 4'h0) != nib_val);

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      crc_acc_reg     <= CRC_SEED;
      nib_cnt_reg     <= '0;
      status_reg      <= '0;
      data_shadow_reg <= '0;
      msg_cnt_reg     <= '0;
      msg_shift_reg   <= '0;
      frame_valid     <= 1'b0;
      status_out      <= '0;
      data_out        <= '0;
      crc_out         <= '0;
      crc_error       <= 1'b0;
      nibble_error    <= 1'b0;
      sync_error      <= 1'b0;
      msg_valid       <= 1'b0;
      msg_data        <= '0;
    end else begin
      frame_valid  <= 1'b0;
      nibble_error <= 1'b0;
      sync_error   <= 1'b0;
      msg_valid    <= 1'b0;
      if (pulse_valid) begin
        // A sync in any state except IDLE/PAUSE/WAIT_SYNC is a resync into STATUS.
        if (is_sync) begin
          state_reg       <= STATUS;
          crc_acc_reg     <= CRC_SEED;
          nib_cnt_reg     <= '0;
          data_shadow_reg <= '0;
        end else begin
          case (state_reg)
            IDLE: ;
            STATUS: begin
              if (is_nib) begin
                status_reg <= nib_val;
                state_reg  <= DATA;
              end else begin
                nibble_error <= 1'b1;
                msg_cnt_reg  <= '0;
                state_reg    <= IDLE;
              end
            end
            DATA: begin
              if (is_nib) begin
                data_shadow_reg <= {data_shadow_reg[19:0], nib_val};
                crc_acc_reg     <= crc_step(crc_acc_reg, nib_val);
                if (nib_cnt_reg == 3'(NIBBLES - 1)) state_reg <= CRC;
                else nib_cnt_reg <= nib_cnt_reg + 3'd1;
              end else begin
                nibble_error <= 1'b1;
                msg_cnt_reg  <= '0;
                state_reg    <= IDLE;
              end
            end
            CRC: begin
              if (is_nib) begin
                frame_valid <= 1'b1;
                status_out  <= status_reg;
                data_out    <= data_shadow_reg;
                crc_out     <= nib_val;
                crc_error   <= crc_bad;
                state_reg   <= (PAUSE_EN != 0) ? PAUSE : WAIT_SYNC;
                // Serial message: bit 3 marks frame 1, bit 2 carries the payload.
                if (crc_bad) begin
                  msg_cnt_reg <= '0;
                end else if (status_reg[3]) begin
                  msg_shift_reg <= {15'b0, status_reg[2]};
                  msg_cnt_reg   <= 4'd1;
                end else if (msg_cnt_reg != 4'd0) begin
                  msg_shift_reg <= {msg_shift_reg[14:0], status_reg[2]};
                  if (msg_cnt_reg == 4'd15) begin
                    msg_valid   <= 1'b1;
                    msg_data    <= {msg_shift_reg[14:0], status_reg[2]};
                    msg_cnt_reg <= '0;
                  end else begin
                    msg_cnt_reg <= msg_cnt_reg + 4'd1;
                  end
                end
              end else begin
                nibble_error <= 1'b1;
                msg_cnt_reg  <= '0;
                state_reg    <= IDLE;
              end
            end
            PAUSE: begin
              if (is_pause) begin
                state_reg <= WAIT_SYNC;
              end else begin
                sync_error  <= 1'b1;
                msg_cnt_reg <= '0;
                state_reg   <= IDLE;
              end
            end
            WAIT_SYNC: begin
              sync_error  <= 1'b1;
              msg_cnt_reg <= '0;
              state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/sent_rx_frame_ctrl.md
# sent_rx_frame_ctrl

Frame-level controller for the SENT (SAE J2716) receive path. It consumes measured nibble periods from the pulse-measurement front end and tracks frame position: sync, status, data nibbles, CRC and optional pause. It checks the CRC4 and delivers complete frames with error flags. It also assembles the 16-frame short serial message carried in status bits 3/2.

## Interface
Parameters:
- NIBBLES, 6, data nibbles per frame (1..6)
- PAUSE_EN, 0, 1 = a pause pulse follows every CRC nibble
- TICK_W, 10, width of the measured period

Ports:
- clk_rx  in  1  receive clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high
- pulse_valid  in  1  one-cycle strobe: a falling-edge-to-falling-edge period has been measured
- pulse_ticks  in  TICK_W  measured period in ticks, valid with pulse_valid
- frame_valid  out  1  one-cycle pulse: frame complete
- status_out  out  4  status nibble of the last frame
- data_out  out  24  data nibbles; first received nibble most significant of the used bits; unused upper bits 0
- crc_out  out  4  received CRC nibble
- crc_error  out  1  valid with frame_valid: computed CRC differs from received CRC
- nibble_error  out  1  one-cycle pulse: period outside 12..27 where a nibble was expected
- sync_error  out  1  one-cycle pulse: non-56 period where a sync was expected
- msg_valid  out  1  one-cycle pulse: 16-frame serial message complete
- msg_data  out  16  status bit 2 of frames 1..16; frame 1 is the MSB

## Operation
- Classification of pulse_ticks:
  - 56 = sync.
  - 12..27 = nibble, with value = ticks−12 (4 bits).
  - 12..768 = pause (pause state only).
  - Any other value is invalid for the current state.
- States: IDLE, STATUS, DATA, CRC, PAUSE, WAIT_SYNC. State changes only on pulse_valid.
- IDLE: sync → STATUS, with crc_acc ← 4'b0101 and nibble count ← 0. Any other period is ignored silently.
- STATUS: nibble → store status, go to DATA. Sync → resync: stay in STATUS, reseed the CRC. Any other period → nibble_error, go to IDLE.
- DATA: each nibble is shifted into data_out_shadow and folded into crc_acc. After NIBBLES nibbles → CRC. Sync → resync to STATUS. Invalid → nibble_error, go to IDLE.
- CRC: nibble → latch outputs and pulse frame_valid; crc_error is asserted if augment(crc_acc) ≠ nibble. Next state is PAUSE if PAUSE_EN, else WAIT_SYNC. Sync → resync to STATUS with no frame output. Invalid → nibble_error, go to IDLE.
- PAUSE: 12..768 → WAIT_SYNC. Sync → STATUS; a missing pause is tolerated. Other → sync_error, go to IDLE.
- WAIT_SYNC: sync → STATUS. Other → sync_error, go to IDLE.
- CRC4 (status nibble excluded):
  - Polynomial x⁴+x³+x²+1, seed 4'b0101.
  - Each data nibble is processed MSB first. Per bit: fb = crc[3]^b; crc = {crc[2:0],0} ^ (fb ? 4'b1101 : 0).
  - augment(crc) = the same loop run on a 4'b0000 nibble.
- Serial message (frames with crc_error=0 only):
  - status[3]=1 → msg count ← 1 and the shift register is loaded with status[2].
  - status[3]=0 with count in 1..15 → shift status[2] in, count+1.
  - A frame that brings the count to 16 pulses msg_valid with msg_data, then count ← 0.
  - status[3]=0 with count 0 → ignored.
  - A frame with crc_error, a nibble_error, or a sync_error → count ← 0.
- Outputs hold their values between frames.

## Timing
- Reset values:
  - All outputs are 0.
  - State = IDLE, crc_acc = 4'b0101, counts = 0.
- frame_valid, crc_error, nibble_error, sync_error and msg_valid are registered. Each asserts the cycle after the pulse_valid that caused it.
- msg_valid coincides with frame_valid of the 16th frame.
- status_out, data_out and crc_out update in the same edge as frame_valid.
- pulse_valid strobes may arrive on consecutive cycles; the block never stalls and has no back-pressure.
- Simultaneous events: a frame-completing pulse that also ends the message produces frame_valid and msg_valid in the same cycle.
- Reset asserted mid-frame:
  - Discards the partial frame and the serial message.
  - Outputs clear immediately (asynchronous).

## Test plan
- Reset mid-frame; release → all outputs 0, state IDLE; next sync starts a fresh frame.
- NIBBLES=6, PAUSE_EN=0. Send 56, status 12, six data periods of 12, CRC period 17 (CRC 5) → frame_valid=1 the next cycle, data_out=24'h000000, crc_out=5, crc_error=0.
- Same frame with CRC period 18 (value 6) → frame_valid=1, crc_error=1; serial message count cleared.
- Periods 56, 12, 12, 30 → nibble_error pulse after the 30, no frame_valid, state IDLE. A following full valid frame is accepted normally.
- PAUSE_EN=1. Valid frame, pause 400, then 56 → no errors. Valid frame, pause 400, then 20 → sync_error.
- 16 valid frames:
  - Frame 1 has status period 20 (status 8, bit3=1).
  - Frames 2..16 have status 16 (status 4, bit2=1) except frame 9, which has status 12 (status 0).
  - Required: msg_valid with the 16th frame_valid, msg_data=16'h7F7F.
